matrix_stream_loader: RTL

- Parametrised successor to the fixed 32x32, 8-bit matrix loader.
- Deserialises a narrow Ethernet-side beat stream into elements and rows, and stores matrix A (row-major) then matrix B (column-major) in two internal row memories.
- Serves row/column read requests to the systolic datapath with fixed latency.
- Adds gap-timeout error detection, a clear/reload path and an optional per-matrix checksum. Single clock domain.

---
 rtl/matrix_stream_loader.sv | 210 +++++++++++++++++++++
 1 files changed

// File: rtl/matrix_stream_loader.sv
`timescale 1ns/1ps
// Beat-stream matrix loader: packs A (row-major) and B (column-major) into row memories, serves 2-cycle reads.
// Optional per-matrix XOR checksum element when MATRIX_LOADER_CHECKSUM_EN is defined.
module matrix_stream_loader #(
  parameter int DIN_W       = 2,
  parameter int ELEM_W      = 8,
  parameter int DIM         = 32,
  parameter int GAP_TIMEOUT = 64
) (
  input  logic                      eth_refclk,
  input  logic                      rst,
  input  logic                      axiiv,
  input  logic [DIN_W-1:0]          axiid,
  input  logic                      clear,
  input  logic                      valid_request,
  input  logic [$clog2(DIM)-1:0]    requested_a_row,
  input  logic [$clog2(DIM)-1:0]    requested_b_col,
  output logic                      valid_out,
  output logic [$clog2(DIM)-1:0]    a_addr_out,
  output logic [$clog2(DIM)-1:0]    b_addr_out,
  output logic [DIM*ELEM_W-1:0]     a_row_out,
  output logic [DIM*ELEM_W-1:0]     b_col_out,
  output logic                      ready,
  output logic                      complete,
  output logic                      error,
  output logic [1:0]                error_code
);

  localparam int BEATS = ELEM_W / DIN_W;
  localparam int AW    = $clog2(DIM);
  localparam int ROW_W = DIM * ELEM_W;
  localparam int BCW   = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int PW    = (BEATS > 1) ? ELEM_W - DIN_W : 1;
  localparam int IW    = $clog2(GAP_TIMEOUT + 1);

  typedef enum logic [2:0] {IDLE, LOAD_A, LOAD_B, READY, ERROR} state_t;

  state_t            state, next_state;
  logic [1:0]        next_code, err_code_q;
  logic              complete_q;
  logic [BCW-1:0]    beat_cnt;
  logic [AW-1:0]     elem_cnt, row_cnt;
  logic [IW-1:0]     idle_cnt;
  logic [PW-1:0]     elem_sr;
  logic [ROW_W-ELEM_W-1:0] row_sr;
  logic [ELEM_W-1:0] cur_elem;
  logic [ROW_W-1:0]  full_row;
  logic [ROW_W-1:0]  mem_a [DIM];
  logic [ROW_W-1:0]  mem_b [DIM];
  logic              loading, beat_fire, elem_done, data_elem, row_done, mat_done, gap_hit;
  logic              csum_phase, csum_ok, csum_bad, matrix_ok;
  logic              req_v1, accept, flush;
  logic [AW-1:0]     a_idx1, b_idx1;

  // The element being completed always includes the beat presented this cycle.
  generate
    if (BEATS > 1) begin : g_multi_beat
      assign cur_elem = {elem_sr, axiid};
    end else begin : g_single_beat
      assign cur_elem = axiid;
    end
  endgenerate

  assign full_row  = {row_sr, cur_elem};
  assign loading   = (state == LOAD_A) || (state == LOAD_B);
  assign beat_fire = axiiv && ((state == IDLE) || loading);
  assign elem_done = beat_fire && (beat_cnt == BCW'(BEATS - 1));
  assign data_elem = elem_done && !csum_phase;
  assign row_done  = data_elem && (elem_cnt == AW'(DIM - 1));
  assign mat_done  = row_done && (row_cnt == AW'(DIM - 1));
  assign gap_hit   = loading && !axiiv && (idle_cnt == IW'(GAP_TIMEOUT - 1));

`ifdef MATRIX_LOADER_CHECKSUM_EN
  logic [ELEM_W-1:0] xor_acc;
  assign csum_ok   = elem_done && csum_phase && (cur_elem == xor_acc);
  assign csum_bad  = elem_done && csum_phase && (cur_elem != xor_acc);
  assign matrix_ok = csum_ok;
`else
  assign csum_phase = 1'b0;
  assign csum_ok    = 1'b0;
  assign csum_bad   = 1'b0;
  assign matrix_ok  = mat_done;
`endif

  always_ff @(posedge eth_refclk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      err_code_q <= 2'b00;
      complete_q <= 1'b0;
    end else begin
      state      <= next_state;
      complete_q <= (next_state == READY) && (state != READY);
      if (next_state != ERROR)
        err_code_q <= 2'b00;
      else if (state != ERROR)
        err_code_q <= next_code;
    end
  end

  always_comb begin
    next_state = state;
    next_code  = 2'b00;
    case (state)
      IDLE:   if (axiiv) next_state = LOAD_A;
      LOAD_A, LOAD_B: begin
        if (gap_hit) begin
          next_state = ERROR;
          next_code  = 2'b01;
        end else if (csum_bad) begin
          next_state = ERROR;
          next_code  = 2'b10;
        end else if (matrix_ok) begin
          next_state = (state == LOAD_A) ? LOAD_B : READY;
        end
      end
      READY, ERROR: if (clear) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    ready      = (state == READY);
    error      = (state == ERROR);
    error_code = err_code_q;
    complete   = complete_q;
  end

  // Counters run only while a load may be in progress; READY/ERROR park them at zero for the next load.
  always_ff @(posedge eth_refclk or posedge rst) begin
    if (rst) begin
      beat_cnt <= '0;
      elem_cnt <= '0;
      row_cnt  <= '0;
      idle_cnt <= '0;
      elem_sr  <= '0;
      row_sr   <= '0;
`ifdef MATRIX_LOADER_CHECKSUM_EN
      csum_phase <= 1'b0;
      xor_acc    <= '0;
`endif
    end else if (!((state == IDLE) || loading)) begin
      beat_cnt <= '0;
      elem_cnt <= '0;
      row_cnt  <= '0;
      idle_cnt <= '0;
`ifdef MATRIX_LOADER_CHECKSUM_EN
      csum_phase <= 1'b0;
      xor_acc    <= '0;
`endif
    end else begin
      idle_cnt <= (loading && !axiiv) ? idle_cnt + 1'b1 : '0;
      if (beat_fire) begin
        elem_sr  <= cur_elem[PW-1:0];
        beat_cnt <= elem_done ? '0 : beat_cnt + 1'b1;
      end
      if (data_elem) begin
        row_sr   <= full_row[ROW_W-ELEM_W-1:0];
        elem_cnt <= elem_cnt + 1'b1;
        if (row_done) row_cnt <= row_cnt + 1'b1;
      end
`ifdef MATRIX_LOADER_CHECKSUM_EN
      if (data_elem) begin
        xor_acc <= xor_acc ^ cur_elem;
        if (mat_done) csum_phase <= 1'b1;
      end else if (elem_done) begin
        csum_phase <= 1'b0;
        xor_acc    <= '0;
      end
`endif
    end
  end

  always_ff @(posedge eth_refclk) begin
    if (row_done) begin
      if (state == LOAD_B) mem_b[row_cnt] <= full_row;
      else                 mem_a[row_cnt] <= full_row;
    end
  end

  // Two-stage read: capture index, then register memory data; a clear in READY flushes stage one.
  assign accept = valid_request && (state == READY) && !clear;
  assign flush  = (state == READY) && clear;

  always_ff @(posedge eth_refclk or posedge rst) begin
    if (rst) begin
      req_v1     <= 1'b0;
      a_idx1     <= '0;
      b_idx1     <= '0;
      valid_out  <= 1'b0;
      a_addr_out <= '0;
      b_addr_out <= '0;
      a_row_out  <= '0;
      b_col_out  <= '0;
    end else begin
      req_v1    <= accept;
      valid_out <= req_v1 && !flush;
      if (accept) begin
        a_idx1 <= requested_a_row;
        b_idx1 <= requested_b_col;
      end
      if (req_v1 && !flush) begin
        a_addr_out <= a_idx1;
        b_addr_out <= b_idx1;
        a_row_out  <= mem_a[a_idx1];
        b_col_out  <= mem_b[b_idx1];
      end
    end
  end

endmodule
